// File: rtl/game_scene_ctrl.sv
// game_scene_ctrl: READY/PLAY/DEAD game FSM, saturating BCD pipe scoring, high score and 2-stage pixel compositor.
// Latency: hCount/vCount -> rgb is 2 clk; state, score and flash counter update on the clk after their trigger.
// No backpressure: the pixel path accepts a new pixel every clock and game inputs are sampled every clock.
module game_scene_ctrl #(
  parameter int          NUM_PIPES    = 2,
  parameter int          BIRD_X       = 200,
  parameter int          SPRITE_W     = 24,
  parameter int          SPRITE_H     = 24,
  parameter int          PIPE_W       = 52,
  parameter int          SCORE_DIGITS = 4,
  parameter logic [11:0] BG_COLOR     = 12'h5CC,
  parameter logic [11:0] PIPE_COLOR   = 12'h0F0,
  parameter logic [11:0] FLASH_COLOR  = 12'hFFF,
  parameter logic [11:0] KEY_COLOR    = 12'h000,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bright,
  input  logic [9:0]                hCount,
  input  logic [9:0]                vCount,
  input  logic                      frame_tick,
  input  logic                      button,
  input  logic [9:0]                bird_y,
  input  logic                      bird_hit,
  input  logic [10*NUM_PIPES-1:0]   pipe_x,
  input  logic [NUM_PIPES-1:0]      pipe_pixel,
  input  logic [11:0]               sprite_px,
  output logic [4:0]                sprite_row,
  output logic [4:0]                sprite_col,
  output logic [11:0]               rgb,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [4*SCORE_DIGITS-1:0] hi_score,
  output logic [1:0]                game_state,
  output logic                      run_en
);

  localparam logic [1:0] ST_READY = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_DEAD  = 2'b10;

  localparam int            FW         = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);
  localparam logic [FW-1:0] FLASH_INIT = FW'(FLASH_FRAMES);

  // Geometry compared in 11 bits so that pipe_x + PIPE_W and bird_y + SPRITE_H cannot wrap
  localparam logic [10:0] BIRD_X_W   = 11'(BIRD_X);
  localparam logic [10:0] PIPE_W_W   = 11'(PIPE_W);
  localparam logic [10:0] SPRITE_W_W = 11'(SPRITE_W);
  localparam logic [10:0] SPRITE_H_W = 11'(SPRITE_H);

  logic [1:0]                state;
  logic [FW-1:0]             flash_cnt;
  logic [NUM_PIPES-1:0]      passed;
  logic [NUM_PIPES-1:0]      respawn;
  logic [NUM_PIPES-1:0]      cleared;
  logic [NUM_PIPES-1:0]      inc_sel;
  logic                      found;
  logic                      button_q;
  logic                      btn_rise;
  logic [4*SCORE_DIGITS-1:0] score_next;
  logic                      carry;
  logic                      at_max;
  logic [3:0]                dig;

  logic [10:0] h_w;
  logic [10:0] v_w;
  logic [10:0] by_w;
  logic        in_sprite;
  logic        flash_on;

  logic bright_s1;
  logic sprite_s1;
  logic pipe_s1;
  logic flash_s1;

  assign btn_rise   = button & ~button_q;
  assign game_state = state;
  assign run_en     = (state == ST_PLAY);

  // Sprite ROM address; only meaningful while the pixel is inside the sprite box
  assign sprite_row = 5'(vCount - bird_y);
  assign sprite_col = 5'(hCount - 10'(BIRD_X));

  assign h_w       = {1'b0, hCount};
  assign v_w       = {1'b0, vCount};
  assign by_w      = {1'b0, bird_y};
  assign in_sprite = (h_w >= BIRD_X_W) && (h_w < BIRD_X_W + SPRITE_W_W) &&
                     (v_w >= by_w) && (v_w < by_w + SPRITE_H_W);
  assign flash_on  = (state == ST_DEAD) && flash_cnt[0];

  // Per-pipe respawn/cleared flags and the single lowest-index pipe that scores this tick
  always_comb begin
    respawn = '0;
    cleared = '0;
    inc_sel = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      respawn[i] = ({1'b0, pipe_x[10*i +: 10]} >= BIRD_X_W);
      cleared[i] = frame_tick && !passed[i] &&
                   (({1'b0, pipe_x[10*i +: 10]} + PIPE_W_W) < BIRD_X_W);
    end
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (cleared[i] && !found) begin
        inc_sel[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // BCD +1 with per-digit carry; an all-nines score holds instead of wrapping
  always_comb begin
    score_next = score;
    carry      = 1'b1;
    at_max     = 1'b1;
    dig        = 4'd0;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      dig = score[4*d +: 4];
      if (dig != 4'd9) at_max = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          score_next[4*d +: 4] = 4'd0;
        end else begin
          score_next[4*d +: 4] = dig + 4'd1;
          carry                = 1'b0;
        end
      end
    end
    if (at_max) score_next = score;
  end

  // Button edge detector register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) button_q <= 1'b0;
    else       button_q <= button;
  end

  // Game FSM with scoring, high score capture and death-flash countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_READY;
      score     <= '0;
      hi_score  <= '0;
      flash_cnt <= '0;
      passed    <= '0;
    end else begin
      case (state)
        ST_READY: begin
          if (btn_rise) begin
            state  <= ST_PLAY;
            score  <= '0;
            passed <= '0;
          end
        end
        ST_PLAY: begin
          if (bird_hit) begin
            // Death wins over any point earned on the same cycle
            state     <= ST_DEAD;
            flash_cnt <= FLASH_INIT;
            if (score > hi_score) hi_score <= score;
          end else begin
            passed <= (passed & ~respawn) | inc_sel;
            if (|inc_sel) score <= score_next;
          end
        end
        ST_DEAD: begin
          if (frame_tick && (flash_cnt != '0)) flash_cnt <= flash_cnt - FW'(1);
          if (btn_rise && (flash_cnt == '0))   state     <= ST_READY;
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // Pixel stage 1: register the layer-select flags alongside the ROM lookup
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bright_s1 <= 1'b0;
      sprite_s1 <= 1'b0;
      pipe_s1   <= 1'b0;
      flash_s1  <= 1'b0;
    end else begin
      bright_s1 <= bright;
      sprite_s1 <= in_sprite;
      pipe_s1   <= |pipe_pixel;
      flash_s1  <= flash_on;
    end
  end

  // Pixel stage 2: layer priority blank > opaque sprite > pipe > flash > background
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= 12'h000;
    end else if (!bright_s1) begin
      rgb <= 12'h000;
    end else if (sprite_s1 && (sprite_px != KEY_COLOR)) begin
      rgb <= sprite_px;
    end else if (pipe_s1) begin
      rgb <= PIPE_COLOR;
    end else if (flash_s1) begin
      rgb <= FLASH_COLOR;
    end else begin
      rgb <= BG_COLOR;
    end
  end

endmodule
